// File: rtl/fnd_scan_mux.sv
// ---------------------------------------------------------------------------
// fnd_scan_mux
//   Selects one of NUM_CH binary channel values, saturates it to 9999,
//   converts it to four BCD digits with a sequential shift-add-3 engine and
//   scans the digits onto a 4-digit multiplexed 7-segment display.
//
// Parameters
//   NUM_CH    : number of input channels (2..8)
//   DATA_W    : width of each channel value (4..14)
//   SCAN_DIV  : clk cycles per digit-scan tick (>= 2)
//   ROT_TICKS : scan ticks per channel dwell in auto-rotate mode (>= 1)
//
// Ports
//   clk      : system clock
//   reset    : asynchronous active-low reset
//   ch_data  : packed channel values, channel k at [k*DATA_W +: DATA_W]
//   sel      : manual channel select, lowest set bit wins, 0 = show 0
//   auto_en  : 1 = rotate through channels, overriding sel
//   fndFont  : segments {dp,g,f,e,d,c,b,a}, active-low, registered
//   fndCom   : digit commons, active-low, bit 0 = ones digit, registered
//   ch_idx   : index of the channel currently displayed
//
// Build option
//   FND_LZ_BLANK_EN : when defined, leading zeros above the ones digit
//                     are blanked.
// ---------------------------------------------------------------------------
module fnd_scan_mux #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 8,
    parameter int SCAN_DIV  = 100000,
    parameter int ROT_TICKS = 4000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH*DATA_W-1:0]  ch_data,
    input  logic [NUM_CH-1:0]         sel,
    input  logic                      auto_en,
    output logic [7:0]                fndFont,
    output logic [3:0]                fndCom,
    output logic [$clog2(NUM_CH)-1:0] ch_idx
);

    localparam int IDX_W  = $clog2(NUM_CH);
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int ROT_W  = (ROT_TICKS > 1) ? $clog2(ROT_TICKS) : 1;
    localparam int CNT_W  = $clog2(DATA_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // 7-segment code for one BCD digit, active-low {dp,g,f,e,d,c,b,a}
    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_e              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [DATA_W-1:0]   bin_q;
    logic [15:0]         work_q;
    logic [3:0][3:0]     digit_q;
    logic [SCAN_W-1:0]   scan_cnt_q;
    logic [1:0]          digit_idx_q;
    logic [ROT_W-1:0]    dwell_q;
    logic [IDX_W-1:0]    ch_idx_q;
    logic                auto_en_q;
    logic [7:0]          fnd_font_q;
    logic [3:0]          fnd_com_q;

    // -----------------------------------------------------------------------
    // Channel selection and saturation
    // -----------------------------------------------------------------------
    logic [IDX_W-1:0]  low_idx;
    logic [DATA_W-1:0] sel_val;
    logic [DATA_W-1:0] sat_val;

    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        low_idx = '0;
        // Scanning downward lets the lowest set bit overwrite higher ones.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (sel[k]) low_idx = IDX_W'(k);
        end
    end

    always_comb begin
        sel_val = '0;
        if (auto_en)
            sel_val = ch_data[int'(ch_idx_q)*DATA_W +: DATA_W];
        else if (|sel)
            sel_val = ch_data[int'(low_idx)*DATA_W +: DATA_W];
    end

    // Only a 14-bit channel can exceed 9999; narrower ones never take this arm.
    always_comb begin
        sat_val = sel_val;
        if (int'(sel_val) > 9999) sat_val = DATA_W'(9999);
    end

    // -----------------------------------------------------------------------
    // Binary-to-BCD FSM: state register / next state / outputs
    // -----------------------------------------------------------------------
    logic load_en, shift_en, done_en;
    logic last_bit;

    assign last_bit = (bit_cnt_q == CNT_W'(DATA_W - 1));

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_LOAD;
            S_LOAD:  state_d = S_SHIFT;
            S_SHIFT: if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        load_en  = (state_q == S_LOAD);
        shift_en = (state_q == S_SHIFT);
        done_en  = (state_q == S_DONE);
    end

    // Add 3 to every BCD nibble that is 5 or more before the next shift.
    logic [15:0] work_adj;
    always_comb begin
        work_adj = work_q;
        for (int i = 0; i < 4; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt_q <= '0;
            bin_q     <= '0;
            work_q    <= '0;
            digit_q   <= '0;
        end else begin
            if (load_en) begin
                bin_q     <= sat_val;
                work_q    <= '0;
                bit_cnt_q <= '0;
            end
            if (shift_en) begin
                {work_q, bin_q} <= {work_adj[14:0], bin_q, 1'b0};
                bit_cnt_q       <= bit_cnt_q + 1'b1;
            end
            // All four digits commit together, so the display never mixes
            // digits of two different conversions.
            if (done_en) digit_q <= work_q;
        end
    end

    // -----------------------------------------------------------------------
    // Scan timing and channel rotation
    // -----------------------------------------------------------------------
    logic tick;
    logic auto_rise;

    assign tick      = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    assign auto_rise = auto_en && !auto_en_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_cnt_q  <= '0;
            digit_idx_q <= '0;
        end else begin
            scan_cnt_q <= tick ? '0 : scan_cnt_q + 1'b1;
            if (tick) digit_idx_q <= digit_idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            auto_en_q <= 1'b0;
            dwell_q   <= '0;
            ch_idx_q  <= '0;
        end else begin
            auto_en_q <= auto_en;
            if (!auto_en) begin
                dwell_q  <= '0;
                ch_idx_q <= low_idx;
            end else if (auto_rise) begin
                dwell_q  <= '0;
                ch_idx_q <= '0;
            end else if (tick) begin
                if (dwell_q == ROT_W'(ROT_TICKS - 1)) begin
                    dwell_q  <= '0;
                    ch_idx_q <= (ch_idx_q == IDX_W'(NUM_CH - 1)) ? '0 : ch_idx_q + 1'b1;
                end else begin
                    dwell_q <= dwell_q + 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Display drive
    // -----------------------------------------------------------------------
    logic [3:0] blank;
    logic [7:0] font_d;

    always_comb begin
`ifdef FND_LZ_BLANK_EN
        blank    = '0;
        blank[3] = (digit_q[3] == 4'd0);
        blank[2] = blank[3] && (digit_q[2] == 4'd0);
        blank[1] = blank[2] && (digit_q[1] == 4'd0);
`else
        blank = '0;
`endif
    end

    always_comb begin
        font_d = blank[digit_idx_q] ? 8'hFF : seg7(digit_q[digit_idx_q]);
    end

    // Font and common are both registered from the same digit index so they
    // switch on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fnd_font_q <= 8'hFF;
            fnd_com_q  <= 4'b1111;
        end else begin
            fnd_font_q <= font_d;
            fnd_com_q  <= ~(4'b0001 << digit_idx_q);
        end
    end

    assign fndFont = fnd_font_q;
    assign fndCom  = fnd_com_q;
    assign ch_idx  = ch_idx_q;

endmodule

// File: tb/tb_fnd_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_fnd_scan_mux
//   Self-checking bench for fnd_scan_mux (NUM_CH=4, DATA_W=14, SCAN_DIV=4,
//   ROT_TICKS=2). Expected display contents come from a decimal model of
//   the channel values; the display is read back one full scan frame at a
//   time through fndCom/fndFont.
// ---------------------------------------------------------------------------
module tb_fnd_scan_mux;

    localparam int NUM_CH    = 4;
    localparam int DATA_W    = 14;
    localparam int SCAN_DIV  = 4;
    localparam int ROT_TICKS = 2;
    localparam int SETTLE    = 2 * (DATA_W + 4) + 2;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_CH*DATA_W-1:0]  ch_data;
    logic [NUM_CH-1:0]         sel;
    logic                      auto_en;
    logic [7:0]                fndFont;
    logic [3:0]                fndCom;
    logic [$clog2(NUM_CH)-1:0] ch_idx;

    int vals [NUM_CH];
    int n_cmp = 0;
    int n_bad = 0;

    fnd_scan_mux #(
        .NUM_CH    (NUM_CH),
        .DATA_W    (DATA_W),
        .SCAN_DIV  (SCAN_DIV),
        .ROT_TICKS (ROT_TICKS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ch_data (ch_data),
        .sel     (sel),
        .auto_en (auto_en),
        .fndFont (fndFont),
        .fndCom  (fndCom),
        .ch_idx  (ch_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply();
        for (int k = 0; k < NUM_CH; k++) ch_data[k*DATA_W +: DATA_W] = DATA_W'(vals[k]);
    endtask

    // ---- reference model ---------------------------------------------------
    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] exp_font(input int value, input int pos);
        int v;
        int p;
        v = (value > 9999) ? 9999 : value;
        p = 1;
        for (int i = 0; i < pos; i++) p = p * 10;
`ifdef FND_LZ_BLANK_EN
        if (pos > 0 && v < p) return 8'hFF;
`endif
        return seg_of((v / p) % 10);
    endfunction

    function automatic int model_idx(input logic [NUM_CH-1:0] s);
        for (int i = 0; i < NUM_CH; i++) if (s[i]) return i;
        return 0;
    endfunction

    function automatic int model_val(input logic [NUM_CH-1:0] s);
        return (s == '0) ? 0 : vals[model_idx(s)];
    endfunction

    // Wait for the start of digit 0, then read all four digit slots.
    task automatic show_frame(input string tag, input int value);
        logic [3:0] prev;
        logic [3:0] exp_com;
        logic [7:0] exp_seg;
        bit         found;
        prev  = fndCom;
        found = 1'b0;
        for (int i = 0; i < 4 * SCAN_DIV + 4 && !found; i++) begin
            @(negedge clk);
            if (fndCom == 4'b1110 && prev != 4'b1110) found = 1'b1;
            else prev = fndCom;
        end
        check({tag, "_start"}, 32'(found), 32'd1);
        if (found) begin
            for (int s = 0; s < 4; s++) begin
                exp_com = 4'b1111;
                exp_com[s] = 1'b0;
                exp_seg = exp_font(value, s);
                check($sformatf("%s_com%0d", tag, s), 32'(fndCom), 32'(exp_com));
                check($sformatf("%s_dig%0d", tag, s), 32'(fndFont), 32'(exp_seg));
                cycles(SCAN_DIV);
            end
        end
    endtask

    // ---- stimulus ------------------------------------------------------------
    initial begin
        int prev_idx;
        int run;
        int changes;

        reset   = 1'b0;
        sel     = '0;
        auto_en = 1'b0;
        ch_data = '0;
        for (int k = 0; k < NUM_CH; k++) vals[k] = 0;
        apply();

        // Reset state: blank display, channel 0
        cycles(3);
        check("rst_com",  32'(fndCom),  32'h0000000F);
        check("rst_font", 32'(fndFont), 32'h000000FF);
        check("rst_idx",  32'(ch_idx),  32'd0);
        reset = 1'b1;
        cycles(1);
        check("first_com", 32'(fndCom), 32'h0000000E);

        // Manual select: 42 on channel 2
        for (int k = 0; k < NUM_CH; k++) vals[k] = $urandom_range(0, 16383);
        vals[2] = 42;
        sel = 4'b0100;
        apply();
        cycles(SETTLE);
        check("v42_idx", 32'(ch_idx), 32'd2);
        show_frame("v42", 42);

        // Saturation: 12345 on channel 1, lowest set bit of 1010 is bit 1
        vals[1] = 12345;
        sel = 4'b1010;
        apply();
        cycles(SETTLE);
        check("sat_idx", 32'(ch_idx), 32'd1);
        show_frame("sat", 12345);

        // No channel selected
        sel = '0;
        cycles(SETTLE);
        check("nosel_idx", 32'(ch_idx), 32'd0);
        show_frame("nosel", 0);

        // Input change while a conversion is in progress
        vals[0] = 255;
        sel = 4'b0001;
        apply();
        cycles(SETTLE);
        show_frame("mid255", 255);
        cycles($urandom_range(0, DATA_W + 2));
        vals[0] = 7;
        apply();
        cycles(SETTLE);
        show_frame("mid7", 7);

        // Randomized manual selections
        for (int it = 0; it < 12; it++) begin
            for (int k = 0; k < NUM_CH; k++) vals[k] = $urandom_range(0, 16383);
            sel = (it % 4 == 3) ? '0 : NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
            apply();
            cycles(SETTLE);
            check($sformatf("rnd%0d_idx", it), 32'(ch_idx), 32'(model_idx(sel)));
            show_frame($sformatf("rnd%0d", it), model_val(sel));
        end

        // Auto-rotate: starts at 0, then 1,2,3,0,1 each held ROT_TICKS*SCAN_DIV
        sel = 4'b1000;
        cycles(2);
        check("pre_auto_idx", 32'(ch_idx), 32'd3);
        auto_en = 1'b1;
        cycles(1);
        check("auto_start_idx", 32'(ch_idx), 32'd0);
        prev_idx = int'(ch_idx);
        run      = 1;
        changes  = 0;
        for (int c = 0; c < 200 && changes < 5; c++) begin
            @(negedge clk);
            if (int'(ch_idx) != prev_idx) begin
                changes++;
                check($sformatf("rot_next%0d", changes), 32'(ch_idx), 32'((prev_idx + 1) % NUM_CH));
                if (changes > 1)
                    check($sformatf("rot_hold%0d", changes), 32'(run), 32'(ROT_TICKS * SCAN_DIV));
                prev_idx = int'(ch_idx);
                run = 1;
            end else begin
                run++;
            end
        end
        check("rot_count", 32'(changes), 32'd5);

        // Leaving auto mode returns to sel on the next cycle
        auto_en = 1'b0;
        sel = 4'b0100;
        cycles(1);
        check("auto_off_idx", 32'(ch_idx), 32'd2);

        // Reset in the middle of operation
        vals[0] = $urandom_range(0, 9999);
        sel = 4'b0001;
        apply();
        cycles(SETTLE);
        cycles($urandom_range(2, DATA_W));
        reset = 1'b0;
        #1;
        check("mrst_com",  32'(fndCom),  32'h0000000F);
        check("mrst_font", 32'(fndFont), 32'h000000FF);
        check("mrst_idx",  32'(ch_idx),  32'd0);
        cycles(3);
        check("mrst_hold_com", 32'(fndCom), 32'h0000000F);
        reset = 1'b1;
        cycles(1);
        check("mrst_restart_com", 32'(fndCom), 32'h0000000E);
        cycles(DATA_W + 5);
        show_frame("mrst_val", vals[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
